// File: rtl/alu_pkg.sv
// Shared types and constants for the integer execute stage.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } ex_state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [REGW-1:0] rd;
  } ex_entry_t;

endpackage

// File: rtl/alu_ex_stage_slt.sv
// Set-less-than comparator, signed or unsigned, fixed at 32 bits.
module slt (
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        unsigned_flag,
  output logic        lt
);

  // Select signed or unsigned ordering of the two operands
  always_comb begin
    lt = 1'b0;
    if (unsigned_flag) begin
      lt = (opa < opb);
    end else begin
      lt = ($signed(opa) < $signed(opb));
    end
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered RV32I ALU execute stage with a 2-entry skid buffer between
// issue and writeback handshakes.
module alu_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_b5,
  input  logic            in_is_imm,
  input  logic [XLEN-1:0] in_opa,
  input  logic [XLEN-1:0] in_opb,
  input  logic [REGW-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [REGW-1:0] out_rd
);
  import alu_pkg::*;

  ex_state_t       state_r;
  ex_entry_t       m_r;
  ex_entry_t       s_r;
  logic            in_ready_r;
  logic            out_valid_r;

  logic            lt_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] result_s;
  ex_entry_t       new_entry_s;
  logic            in_xfer_s;
  logic            out_xfer_s;

  slt u_slt (
    .opa           (in_opa),
    .opb           (in_opb),
    .unsigned_flag (in_funct3[0]),
    .lt            (lt_s)
  );

  assign shamt_s = in_opb[4:0];

  // Combinational ALU on the presented operation
  always_comb begin
    result_s = {XLEN{1'b0}};
    case (in_funct3)
      F3_ADD: begin
        // Immediate form has no subtract; bit 30 is part of the immediate there
        if (in_funct7_b5 && !in_is_imm) begin
          result_s = in_opa - in_opb;
        end else begin
          result_s = in_opa + in_opb;
        end
      end
      F3_SLL:  result_s = in_opa << shamt_s;
      F3_SLT:  result_s = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: result_s = {{(XLEN-1){1'b0}}, lt_s};
      F3_XOR:  result_s = in_opa ^ in_opb;
      F3_SR: begin
        if (in_funct7_b5) begin
          result_s = $unsigned($signed(in_opa) >>> shamt_s);
        end else begin
          result_s = in_opa >> shamt_s;
        end
      end
      F3_OR:   result_s = in_opa | in_opb;
      F3_AND:  result_s = in_opa & in_opb;
      default: result_s = {XLEN{1'b0}};
    endcase
  end

  assign new_entry_s.result = result_s;
  assign new_entry_s.rd     = in_rd;
  assign in_xfer_s          = in_valid & in_ready_r;
  assign out_xfer_s         = out_valid_r & out_ready;

  // Handshake state machine: main/skid entries and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      m_r         <= '0;
      s_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            m_r         <= new_entry_s;
            state_r     <= FULL;
            out_valid_r <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
          end
          in_ready_r <= 1'b1;
        end
        FULL: begin
          if (in_xfer_s && out_xfer_s) begin
            m_r <= new_entry_s;
          end else if (out_xfer_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end else if (in_xfer_s) begin
            s_r        <= new_entry_s;
            state_r    <= SKID;
            in_ready_r <= 1'b0;
          end else begin
            state_r <= FULL;
          end
        end
        SKID: begin
          if (out_xfer_s) begin
            m_r        <= s_r;
            state_r    <= FULL;
            in_ready_r <= 1'b1;
          end else begin
            state_r <= SKID;
          end
        end
        default: begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = m_r.result;
  assign out_rd     = m_r.rd;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed-vector and scoreboard bench for alu_ex_stage.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_b5;
  logic        in_is_imm;
  logic [31:0] in_opa;
  logic [31:0] in_opb;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        b5;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  logic [36:0] sb_q[$];
  logic        sb_en = 1'b0;
  logic        hold_v = 1'b0;
  logic [36:0] hold_val;

  alu_ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct3    (in_funct3),
    .in_funct7_b5 (in_funct7_b5),
    .in_is_imm    (in_is_imm),
    .in_opa       (in_opa),
    .in_opb       (in_opb),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic b5, input logic imm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0:    return (b5 && !imm) ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return b5 ? $unsigned($signed(a) >>> sh) : (a >> sh);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    in_valid     = 1'b1;
    in_funct3    = v.f3;
    in_funct7_b5 = v.b5;
    in_is_imm    = v.imm;
    in_opa       = v.a;
    in_opb       = v.b;
    in_rd        = v.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: transfers are judged at negedge, where inputs are stable for the next edge
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (hold_v) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", out_result, hold_val[36:5]);
        chk("hold_rd", {27'd0, out_rd}, {27'd0, hold_val[4:0]});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("sb_result", out_result, sb_q[0][36:5]);
          chk("sb_rd", {27'd0, out_rd}, {27'd0, sb_q[0][4:0]});
          void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back({ref_alu(in_funct3, in_funct7_b5, in_is_imm, in_opa, in_opb), in_rd});
      end
      hold_v   <= out_valid && !out_ready;
      hold_val <= {out_result, out_rd};
    end else begin
      hold_v <= 1'b0;
    end
  end

  initial begin
    vec_t v;
    //            f3    b5    imm   a              b              rd     exp
    vecs[0]  = '{3'd2, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001, 5'd5,  32'h0000_0001};
    vecs[1]  = '{3'd3, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001, 5'd6,  32'h0000_0000};
    vecs[2]  = '{3'd0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005, 5'd1,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0021, 5'd2,  32'hC000_0000};
    vecs[4]  = '{3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0021, 5'd3,  32'h4000_0000};
    vecs[5]  = '{3'd0, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0001, 5'd4,  32'h0000_0008};
    vecs[6]  = '{3'd1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_003F, 5'd7,  32'h8000_0000};
    vecs[7]  = '{3'd4, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8,  32'h0FF0_0FF0};
    vecs[8]  = '{3'd6, 1'b0, 1'b0, 32'h0F0F_0000, 32'h0000_00F0, 5'd9,  32'h0F0F_00F0};
    vecs[9]  = '{3'd7, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_FFFF, 5'd10, 32'h0000_5678};
    vecs[10] = '{3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd11, 32'h0000_0000};
    vecs[11] = '{3'd5, 1'b1, 1'b1, 32'h7FFF_FFF0, 32'h0000_0004, 5'd12, 32'h07FF_FFFF};
    vecs[12] = '{3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'd13, 32'h0000_0001};
    vecs[13] = '{3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 32'h0000_0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = 3'd0; in_funct7_b5 = 1'b0; in_is_imm = 1'b0;
    in_opa = 32'd0; in_opb = 32'd0; in_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);

    // Isolated ops: one-cycle latency, then drain to empty
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      tick();
      in_valid = 1'b0;
      chk($sformatf("single_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("single_result[%0d]", i), out_result, vecs[i].exp);
      chk($sformatf("single_rd[%0d]", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      tick();
      chk($sformatf("single_drain[%0d]", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back stream: one result per cycle, in_ready never drops
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("stream_result[%0d]", i), out_result, vecs[i].exp);
      chk($sformatf("stream_rd[%0d]", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("stream_ready[%0d]", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A held, B skidded, C held upstream
    out_ready = 1'b0;
    drive(vecs[7]); tick();
    chk("bp_a_out", out_result, vecs[7].exp);
    chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
    drive(vecs[8]); tick();
    chk("bp_skid_out", out_result, vecs[7].exp);
    chk("bp_skid_ready", {31'd0, in_ready}, 32'd0);
    drive(vecs[9]); tick();
    chk("bp_c_held_out", out_result, vecs[7].exp);
    chk("bp_c_held_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk("bp_b_out", out_result, vecs[8].exp);
    chk("bp_b_rd", {27'd0, out_rd}, {27'd0, vecs[8].rd});
    chk("bp_b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_c_out", out_result, vecs[9].exp);
    chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Reset asserted while in SKID discards both entries
    out_ready = 1'b0;
    drive(vecs[2]); tick();
    drive(vecs[3]); tick();
    chk("pre_rst_skid_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    drive(vecs[5]); tick();
    in_valid = 1'b0;
    chk("post_rst_first", out_result, vecs[5].exp);
    chk("post_rst_first_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Randomised traffic against the scoreboard
    sb_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      v.f3  = 3'($urandom_range(0, 7));
      v.b5  = 1'($urandom_range(0, 1));
      v.imm = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      v.rd  = 5'($urandom_range(0, 31));
      v.exp = 32'd0;
      drive(v);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      tick();
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    sb_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
